// File: rtl/lamp_fader_if.sv
// Lamp fader port bundle: on/off requests and enable in,
// PWM drive and status out.
interface lamp_fader_if #(
  parameter int MX_LP = 16
);
  logic [MX_LP-1:0] a_lamp;
  logic             en;
  logic [MX_LP-1:0] pwm_out;
  logic             fade_busy;
  logic             all_dark;

  modport master (
    output a_lamp,
    output en,
    input  pwm_out,
    input  fade_busy,
    input  all_dark
  );

  modport slave (
    input  a_lamp,
    input  en,
    output pwm_out,
    output fade_busy,
    output all_dark
  );
endinterface

// File: rtl/lamp_fader.sv
// Per-lamp brightness ramp with PWM drive.
// Turns hard on/off lamp requests into smooth fades.
module lamp_fader #(
  parameter int MX_LP    = 16,
  parameter int LVL_W    = 4,
  parameter int STEP_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  lamp_fader_if.slave bus
);

  localparam int MAX_LVL = (1 << LVL_W) - 1;
  localparam int PRE_W   = $clog2(STEP_DIV);

  localparam logic [PRE_W-1:0] PRE_MAX =
    PRE_W'(STEP_DIV - 1);
  localparam logic [LVL_W-1:0] LVL_MAX =
    LVL_W'(MAX_LVL);
  localparam logic [LVL_W-1:0] LVL_ZERO = '0;
  localparam logic [LVL_W-1:0] CNT_MAX =
    LVL_W'(MAX_LVL - 1);

  logic [MX_LP-1:0] lamp_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic [LVL_W-1:0] lvl_q [MX_LP];
  logic [LVL_W-1:0] lvl_d [MX_LP];
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic [MX_LP-1:0] pwm_q, pwm_d;
  logic             busy_q, busy_d;
  logic             dark_q, dark_d;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (bus.en) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Saturating step toward the registered request.
  always_comb begin
    for (int i = 0; i < MX_LP; i++) begin
      lvl_d[i] = lvl_q[i];
      if (tick) begin
        if (lamp_q[i] && lvl_q[i] != LVL_MAX)
          lvl_d[i] = lvl_q[i] + 1'b1;
        else if (!lamp_q[i] && lvl_q[i] != LVL_ZERO)
          lvl_d[i] = lvl_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
  end

  // Counter spans 0..MAX_LVL-1, so full level is steady high.
  always_comb begin
    pwm_d  = '0;
    busy_d = 1'b0;
    dark_d = 1'b1;
    for (int i = 0; i < MX_LP; i++) begin
      pwm_d[i] = (lvl_q[i] > cnt_q);
      if (lvl_q[i] != (lamp_q[i] ? LVL_MAX : LVL_ZERO))
        busy_d = 1'b1;
      if (lvl_q[i] != LVL_ZERO)
        dark_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_q <= '0;
      pre_q  <= '0;
      cnt_q  <= '0;
      pwm_q  <= '0;
      busy_q <= 1'b0;
      dark_q <= 1'b1;
      for (int i = 0; i < MX_LP; i++)
        lvl_q[i] <= '0;
    end else begin
      lamp_q <= bus.a_lamp;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      pwm_q  <= pwm_d;
      busy_q <= busy_d;
      dark_q <= dark_d;
      for (int i = 0; i < MX_LP; i++)
        lvl_q[i] <= lvl_d[i];
    end
  end

  assign bus.pwm_out   = pwm_q;
  assign bus.fade_busy = busy_q;
  assign bus.all_dark  = dark_q;

endmodule

// File: doc/lamp_fader.md
Name: lamp_fader

Overview:
- Downstream of bound_flasher. Consumes its a_lamp vector and drives physical lamp outputs.
- Each on/off lamp bit becomes a per-lamp brightness level that ramps up or down at a fixed rate.
- Each level is emitted as a PWM waveform, so the flasher's hard transitions appear as smooth fades.
- Also reports fade-in-progress and all-dark status to the system controller.

Parameters:
MX_LP, 16, number of lamps; must match bound_flasher's lamp width
LVL_W, 4, brightness level width; MAX_LVL = 2^LVL_W - 1
STEP_DIV, 8, clock cycles per fade step; legal range 2..256

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
a_lamp  input  MX_LP  lamp on/off request from bound_flasher
en  input  1  fade enable; low freezes levels and prescaler
pwm_out  output  MX_LP  PWM lamp drive, registered
fade_busy  output  1  high while any level differs from its target, registered
all_dark  output  1  high when every level is 0, registered

Behaviour:
- Reset:
  - rst high asynchronously clears lamp_q, all levels, prescaler, pwm_cnt, pwm_out and fade_busy to 0, and sets all_dark to 1.
  - The first update after rst deasserts occurs at the next rising edge.
  - Reset mid-fade discards all levels; no fade-out occurs.
- Input stage: lamp_q <= a_lamp every cycle, regardless of en. One cycle of input latency.
- Prescaler (width clog2(STEP_DIV)):
  - If en=1: when pre == STEP_DIV-1, pre <= 0 and tick is asserted for that edge; otherwise pre <= pre+1.
  - If en=0: pre holds and no tick occurs.
- Level update, per lamp i, only on a tick:
  - lamp_q[i]=1 and level[i]<MAX_LVL -> level[i] <= level[i]+1.
  - lamp_q[i]=0 and level[i]>0 -> level[i] <= level[i]-1.
  - Otherwise level[i] holds. Saturating: no wrap at 0 or MAX_LVL.
  - Uses the lamp_q value present before the edge.
- Fade timing: a full ramp 0->MAX_LVL takes MAX_LVL ticks = MAX_LVL*STEP_DIV cycles with en=1 (defaults: 120 cycles).
- Direction reversal: if a_lamp[i] changes mid-ramp, the next tick moves the level one step the other way. No restart or jump.
- PWM counter pwm_cnt (LVL_W bits):
  - Free-running 0..MAX_LVL-1, then wraps to 0; period MAX_LVL cycles.
  - Runs independently of en.
- PWM output: pwm_out[i] <= (level[i] > pwm_cnt), using the pre-edge register values.
  - level 0 -> constant 0.
  - level MAX_LVL -> constant 1.
  - level L -> high for exactly L of every MAX_LVL cycles.
- Status (registered, computed from pre-edge values):
  - fade_busy <= OR over i of (level[i] != (lamp_q[i] ? MAX_LVL : 0)).
  - all_dark <= (all level[i] == 0).
- Simultaneous events: a tick on the same edge as an a_lamp change uses the old lamp_q. The new request takes effect on the following tick.
- en toggling: levels and prescaler resume from their held values; no tick is lost or duplicated.

Test Plan:
1. Reset check: assert rst with a_lamp=16'hFFFF, en=1 -> pwm_out=0, fade_busy=0, all_dark=1 throughout reset; asynchronous clear verified by asserting rst between clock edges.
2. Single-lamp ramp-up (defaults): release rst, a_lamp=16'h0001, en=1 -> level[0] increments every 8 cycles and reaches 15 after 120 cycles; pwm_out[0] then stays 1; fade_busy falls one cycle after level[0]=15; other bits stay 0.
3. Duty check: freeze level[0] at 5 via en=0 -> pwm_out[0] high exactly 5 of every 15 cycles, repeating, while en stays 0.
4. Reversal: ramp lamp 3 to level 9, then set a_lamp[3]=0 -> level steps 8,7,...,0 on successive ticks; all_dark rises one cycle after level 0; no underflow past 0.
5. Full-vector fade: a_lamp alternates 16'hAAAA and 16'h5555 every 200 cycles -> even and odd lamps cross-fade complementarily; levels saturate at 15/0; fade_busy=1 during transitions.
6. Mid-fade reset: assert rst while 16'hFFFF is at level 7 -> outputs clear within the same cycle, without waiting for a clock edge; after release, fade restarts from 0 and reaches 15 after 120 cycles.
